// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and 16 MHz timing defaults for the WS2812 driver.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Driver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Default bit timing at 16 MHz (62.5 ns per cycle)
    localparam int c_T0H_CYC = 6;     // 375 ns
    localparam int c_T1H_CYC = 13;    // 812.5 ns
    localparam int c_BIT_CYC = 20;    // 1.25 us
    localparam int c_RST_CYC = 1280;  // 80 us latch gap
    localparam int c_CNT_W   = 11;

    // One LED pixel in wire order (G first, MSB first)
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_pixel_t;

endpackage
`default_nettype wire

// File: rtl/ws2812_if.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_if
// Description : Valid/ready pixel stream feeding a WS2812 chain driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface ws2812_if;

    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;   // {G, R, B}
    logic        pix_last;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_tx
// Description : WS2812 single-wire NRZ serialiser. Accepts 24-bit GRB pixels
//               over a valid/ready stream, emits them MSB first and closes
//               each frame with a low latch gap.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = c_T0H_CYC,
    parameter int T1H_CYC = c_T1H_CYC,
    parameter int BIT_CYC = c_BIT_CYC,
    parameter int RST_CYC = c_RST_CYC,
    parameter int CNT_W   = c_CNT_W
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    ws2812_if.slave    pix,
    output logic       busy,
    output logic       underrun,
    input  wire logic  underrun_clr,
    output logic       led_dout
);

    state_e             r_state;
    state_e             w_state_next;
    logic [23:0]        r_shift;
    logic               r_last;
    logic [4:0]         r_bit_idx;
    logic [CNT_W-1:0]   r_cyc;
    logic               r_led;
    logic               r_underrun;

    logic               w_bit_end;
    logic               w_pix_end;
    logic               w_latch_end;
    logic               w_ready;
    logic               w_transfer;
    logic               w_underrun_set;
    logic [CNT_W-1:0]   w_thresh;
    logic               w_led_next;

    assign w_bit_end   = (r_cyc == CNT_W'(BIT_CYC - 1));
    assign w_pix_end   = (r_state == ST_SEND) && w_bit_end && (r_bit_idx == 5'd0);
    assign w_latch_end = (r_state == ST_LATCH) && (r_cyc == CNT_W'(RST_CYC - 1));

    // Gated by reset_n so no pixel is ever offered as accepted while in reset
    assign w_ready    = reset_n && ((r_state == ST_IDLE) || (w_pix_end && !r_last));
    assign w_transfer = pix.pix_valid && w_ready;

    assign w_underrun_set = w_pix_end && !w_transfer && !r_last;
    assign w_thresh       = r_shift[23] ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    assign w_led_next     = (r_state == ST_SEND) && (r_cyc < w_thresh);

    assign pix.pix_ready = w_ready;
    assign busy          = (r_state != ST_IDLE);
    assign underrun      = r_underrun;
    assign led_dout      = r_led;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_transfer) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                // A chained transfer keeps us in SEND with no gap
                if (w_pix_end && !w_transfer) w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_latch_end) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pixel shifter, bit index and shared bit/latch cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_last    <= 1'b0;
            r_bit_idx <= '0;
            r_cyc     <= '0;
        end else if (w_transfer) begin
            r_shift   <= pix.pix_data;
            r_last    <= pix.pix_last;
            r_bit_idx <= 5'd23;
            r_cyc     <= '0;
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (w_bit_end) begin
                        r_shift   <= {r_shift[22:0], 1'b0};
                        r_bit_idx <= r_bit_idx - 5'd1;
                        r_cyc     <= '0;
                    end else begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    r_cyc <= w_latch_end ? '0 : r_cyc + CNT_W'(1);
                end
                default: r_cyc <= '0;
            endcase
        end
    end

    // Registered line driver; lags the counter by one cycle so it never glitches
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_next;
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
- Serial driver for the on-board and external WS2812-class RGB LEDs on EX_LED_RGB_D and OB_LED_RGB_D, which are currently tied low at top level.
- Sits downstream of the e203 SoC in the 16 MHz domain (clk_16m). It takes 24-bit GRB pixels over a valid/ready stream and emits the single-wire NRZ waveform, followed by a latch/reset gap.
- One instance per LED chain.

Parameters:
- T0H_CYC, 6: high time of a '0' bit, in clk cycles (375 ns at 16 MHz).
- T1H_CYC, 13: high time of a '1' bit (812.5 ns).
- BIT_CYC, 20: total bit period (1.25 us). Must be greater than T1H_CYC.
- RST_CYC, 1280: latch gap with the line held low (80 us).
- CNT_W, 11: width of the timing counter. Must satisfy 2^CNT_W > RST_CYC.

Ports:
- clk  input  1  Module clock (clk_16m).
- reset_n  input  1  Synchronous reset, active low. Sampled on the rising edge of clk.
- pix_valid  input  1  Pixel available on pix_data/pix_last.
- pix_ready  output  1  Block accepts the pixel this cycle.
- pix_data  input  24  Pixel as {G[7:0],R[7:0],B[7:0]}, sent MSB first.
- pix_last  input  1  Marks the final pixel of the frame.
- busy  output  1  High whenever state is not IDLE.
- underrun  output  1  Sticky flag: the frame ended without pix_last.
- underrun_clr  input  1  Clears underrun.
- led_dout  output  1  Serial LED data line.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, counters=0, led_dout=0, underrun=0.
  - Registered outputs take these values on the next edge.
  - Asserting reset mid-frame aborts the frame immediately. The line drops low and no latch gap is guaranteed.
- pix_ready is combinational:
  - high in IDLE;
  - high on the final cycle of bit 0 (the 24th bit) of a pixel whose last flag is clear.
  - Low at all other times.
- Transfer occurs when pix_valid && pix_ready. On transfer the block loads shift_reg<=pix_data, last_r<=pix_last, bit_idx<=23, cyc<=0.
- FSM states: IDLE, SEND, LATCH.
  - IDLE: led_dout=0. On transfer, go to SEND.
  - SEND: cyc counts 0..BIT_CYC-1.
    - led_dout=1 while cyc < (shift_reg[23] ? T1H_CYC : T0H_CYC), else 0.
    - At cyc=BIT_CYC-1: shift left, decrement bit_idx, cyc<=0.
  - End of pixel (bit_idx=0, cyc=BIT_CYC-1):
    - If a transfer occurs in that same cycle, go straight to the next pixel's first bit. There are no idle cycles between pixels.
    - Else if last_r=1, go to LATCH.
    - Else go to LATCH and set underrun<=1.
  - LATCH: led_dout=0 for exactly RST_CYC cycles, then go to IDLE. pix_ready=0 throughout.
- Latency: a transfer accepted in IDLE at edge N drives led_dout=1 at edge N+1.
- led_dout is registered and glitch-free.
- Pixel timing: each pixel is exactly 24*BIT_CYC cycles. Frame length is N*480 + 1280 cycles at the defaults.
- If underrun_clr and an underrun set coincide, set wins.
- pix_valid deasserted in IDLE: block stays idle indefinitely.
- pix_data/pix_last are sampled only on transfer. Changes at other times are ignored.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum (IDLE/SEND/LATCH);
  - the default timing constants for 16 MHz;
  - a GRB pixel typedef (24-bit struct g, r, b).
- No sub-module; the block is a single FSM plus counters.
- The top level instantiates two copies, fed from a small SoC register bridge. The bridge is a separate block.

Test Plan:
- Single pixel 24'hFF0000 with pix_last=1 from IDLE:
  - the first 8 bits show 13 high / 7 low cycles;
  - the remaining 16 bits show 6 high / 14 low;
  - then 1280 low cycles, then busy=0.
  - Total busy time is 480+1280 cycles.
- Three back-to-back pixels 24'hA5A5A5, 24'h5A5A5A, 24'h000001 (last), with pix_valid held high:
  - pix_ready pulses exactly at cycles 479 and 959 after the first transfer;
  - no gap between pixels;
  - the final bit is 13-cycle high.
- Underrun: one pixel 24'h123456 with pix_last=0, then pix_valid=0:
  - LATCH is entered after 480 cycles and underrun=1;
  - underrun_clr=1 for one cycle returns it to 0;
  - underrun_clr asserted in the same cycle as a new underrun leaves underrun=1.
- Reset mid-pixel: assert reset_n=0 at bit 10 of a frame:
  - the next edge shows led_dout=0, busy=0, pix_ready=0;
  - after release pix_ready=1 and a fresh frame transmits correctly.
- Source stall in IDLE: pix_valid low for 5000 cycles gives led_dout=0 and busy=0 throughout.
  - pix_data toggling while pix_valid is low has no effect on the later transmitted pixel.
